// File: rtl/bsd_stream_ctrl_pkg.sv
// Shared types for the bit-serial detector stream controller.
// Macro BSD_CTRL_LSB_FIRST_EN selects LSB-first serialisation (default MSB-first).
package bsd_pkg;

   localparam int CNT_W_DEF = 8;
   localparam int BYTE_W    = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // Bit presented to the detector from the current shift-register contents.
   function automatic logic head_bit(input logic [BYTE_W-1:0] s);
`ifdef BSD_CTRL_LSB_FIRST_EN
      return s[0];
`else
      return s[BYTE_W-1];
`endif
   endfunction

   function automatic logic [BYTE_W-1:0] advance(input logic [BYTE_W-1:0] s);
`ifdef BSD_CTRL_LSB_FIRST_EN
      return {1'b0, s[BYTE_W-1:1]};
`else
      return {s[BYTE_W-2:0], 1'b0};
`endif
   endfunction

endpackage

// File: rtl/bsd_stream_ctrl_if.sv
// Byte stream, detector and status signals of bsd_stream_ctrl.
// Macro BSD_CTRL_LSB_FIRST_EN does not change this interface.
interface bsd_stream_ctrl_if #(
   parameter int CNT_W = bsd_pkg::CNT_W_DEF
);

   // Handshake: a byte transfers at a rising edge where byte_valid and
   // byte_ready are both 1; clr in the same cycle wins and drops the byte.
   logic             clr;
   logic [7:0]       byte_in;
   logic             byte_valid;
   logic             byte_ready;
   logic             det_bit;
   logic             det_en;
   logic             det_clr;
   logic             det_hit;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] match_cnt;
   logic             ovf;

   modport master (
      output clr, byte_in, byte_valid, det_hit,
      input  byte_ready, det_bit, det_en, det_clr, busy, done, match_cnt, ovf
   );

   modport slave (
      input  clr, byte_in, byte_valid, det_hit,
      output byte_ready, det_bit, det_en, det_clr, busy, done, match_cnt, ovf
   );

endinterface

// File: rtl/bsd_sat_cnt.sv
// Saturating hit counter with a sticky overflow flag.
// Macro BSD_CTRL_LSB_FIRST_EN has no effect here.
module bsd_sat_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt,
   output logic         ovf
);

   localparam logic [W-1:0] CNT_MAX = '1;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
         ovf <= 1'b0;
      end else if (inc) begin
         // A hit at full scale is recorded in ovf instead of wrapping.
         if (cnt == CNT_MAX) begin
            ovf <= 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/bsd_stream_ctrl.sv
// Serialises accepted bytes to a sequence detector and counts its hits.
// Macro BSD_CTRL_LSB_FIRST_EN selects LSB-first serialisation (default MSB-first).
module bsd_stream_ctrl
   import bsd_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   bsd_stream_ctrl_if.slave    bus,
   output state_t              fsm_state
);

   state_t            state_q, state_d;
   logic [BYTE_W-1:0] sreg_q, sreg_d;
   logic [2:0]        bit_q, bit_d;
   logic              done_q, done_d;
   logic              det_clr_q;
   logic              last_bit;
   logic              ready;
   logic              xfer;

   assign last_bit = (state_q == SHIFT) && (bit_q == 3'd7);
   assign ready    = (state_q == IDLE) || last_bit;
   assign xfer     = bus.byte_valid && ready;

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      bit_d   = bit_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (xfer) begin
               state_d = SHIFT;
               sreg_d  = bus.byte_in;
               bit_d   = 3'd0;
            end
         end
         SHIFT: begin
            if (last_bit) begin
               // Reloading here keeps the serial stream gap-free.
               if (xfer) begin
                  sreg_d = bus.byte_in;
                  bit_d  = 3'd0;
               end else begin
                  state_d = FLUSH;
               end
            end else begin
               sreg_d = advance(sreg_q);
               bit_d  = bit_q + 3'd1;
            end
         end
         FLUSH: begin
            // One spare cycle lets the last registered hit reach the counter.
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (bus.clr) begin
         state_d = IDLE;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         sreg_q    <= '0;
         bit_q     <= 3'd0;
         done_q    <= 1'b0;
         det_clr_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         sreg_q    <= sreg_d;
         bit_q     <= bit_d;
         done_q    <= done_d;
         det_clr_q <= bus.clr;
      end
   end

   bsd_sat_cnt #(
      .W (CNT_W)
   ) u_sat_cnt (
      .clk (clk),
      .rst (rst),
      .clr (bus.clr),
      .inc (bus.det_hit),
      .cnt (bus.match_cnt),
      .ovf (bus.ovf)
   );

   assign bus.byte_ready = ready;
   assign bus.det_en     = (state_q == SHIFT);
   assign bus.det_bit    = (state_q == SHIFT) && head_bit(sreg_q);
   assign bus.det_clr    = det_clr_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.done       = done_q;
   assign fsm_state      = state_q;

endmodule

// File: tb/tb_bsd_stream_ctrl.sv
// Bench for bsd_stream_ctrl with a behavioural overlapping "1011" detector.
// Honours BSD_CTRL_LSB_FIRST_EN for expected bit order.
module tb_bsd_stream_ctrl;
   import bsd_pkg::*;

   localparam int CNT_W   = CNT_W_DEF;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic   clk = 1'b0;
   logic   rst;
   state_t fsm_state;

   bsd_stream_ctrl_if #(.CNT_W(CNT_W)) bus ();

   bsd_stream_ctrl #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .fsm_state (fsm_state)
   );

   always #5 clk = ~clk;

   // Environment detector: overlapping "1011", hit registered one cycle later.
   logic [2:0] env_win = 3'd0;
   logic       env_hit = 1'b0;
   always_ff @(posedge clk) begin
      if (bus.det_clr) begin
         env_win <= 3'd0;
         env_hit <= 1'b0;
      end else if (bus.det_en) begin
         env_hit <= ({env_win, bus.det_bit} == 4'b1011);
         env_win <= {env_win[1:0], bus.det_bit};
      end else begin
         env_hit <= 1'b0;
      end
   end
   assign bus.det_hit = env_hit;

   // Reference model: queue of bits still owed to the detector.
   bit       mq[$];
   bit       m_flush = 1'b0;
   bit       m_done  = 1'b0;
   bit       m_dclr  = 1'b0;
   bit       m_hit   = 1'b0;
   bit       m_ovf   = 1'b0;
   bit [2:0] m_win   = 3'd0;
   int       m_cnt   = 0;

   int n_vec = 0;
   int n_bad = 0;
   int obs_en_cnt = 0;
   int obs_done_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_ready();
      return (mq.size() == 0 && !m_flush) || (mq.size() == 1);
   endfunction

   task automatic push_byte(input logic [7:0] b);
`ifdef BSD_CTRL_LSB_FIRST_EN
      for (int i = 0; i < 8; i++) mq.push_back(b[i]);
`else
      for (int i = 7; i >= 0; i--) mq.push_back(b[i]);
`endif
   endtask

   task automatic model_edge();
      bit en, b, acc, nh;
      en  = (mq.size() > 0);
      b   = en ? mq[0] : 1'b0;
      acc = bus.byte_valid && m_ready();
      nh  = 1'b0;
      if (m_dclr) begin
         m_win = 3'd0;
      end else if (en) begin
         nh    = ({m_win, b} == 4'b1011);
         m_win = {m_win[1:0], b};
      end
      if (rst || bus.clr) begin
         mq.delete();
         m_flush = 1'b0;
         m_done  = 1'b0;
         m_cnt   = 0;
         m_ovf   = 1'b0;
         m_dclr  = 1'b1;
      end else begin
         m_dclr = 1'b0;
         if (m_hit) begin
            if (m_cnt == CNT_MAX) m_ovf = 1'b1;
            else m_cnt++;
         end
         m_done = m_flush;
         if (en) begin
            void'(mq.pop_front());
            if (mq.size() == 0) begin
               if (acc) push_byte(bus.byte_in);
               else m_flush = 1'b1;
            end
         end else if (m_flush) begin
            m_flush = 1'b0;
         end else if (acc) begin
            push_byte(bus.byte_in);
         end
      end
      m_hit = nh;
   endtask

   task automatic check_outputs();
      bit en;
      en = (mq.size() > 0);
      chk("byte_ready", bus.byte_ready, m_ready());
      chk("det_en", bus.det_en, en);
      chk("det_bit", bus.det_bit, en ? mq[0] : 1'b0);
      chk("det_clr", bus.det_clr, m_dclr);
      chk("busy", bus.busy, en || m_flush);
      chk("done", bus.done, m_done);
      chk("match_cnt", bus.match_cnt, m_cnt);
      chk("ovf", bus.ovf, m_ovf);
      chk("state_idle", fsm_state == IDLE, !(en || m_flush));
      obs_en_cnt   += (bus.det_en === 1'b1) ? 1 : 0;
      obs_done_cnt += (bus.done === 1'b1) ? 1 : 0;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit acc;
      int g;
      g = 0;
      bus.byte_valid = 1'b1;
      bus.byte_in    = b;
      do begin
         acc = m_ready();
         tick();
         g++;
      end while (!acc && g < 20);
      chk("send_accept", acc, 1'b1);
      bus.byte_valid = 1'b0;
   endtask

   task automatic wait_done();
      int g;
      g = 0;
      while (!m_done && g < 60) begin
         tick();
         g++;
      end
      chk("done_seen", bus.done, 1'b1);
   endtask

   task automatic clear_ctx();
      bus.clr = 1'b1;
      tick();
      bus.clr = 1'b0;
      tick();
   endtask

   logic [7:0] pat;
   logic [7:0] sat_tab [3];

   initial begin
      rst = 1'b1;
      bus.clr = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_in = 8'h00;

      // Reset for two cycles.
      tick();
      tick();
      chk("rst_ready", bus.byte_ready, 1'b1);
      chk("rst_dclr", bus.det_clr, 1'b1);
      chk("rst_cnt", bus.match_cnt, 0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      rst = 1'b0;
      tick();
      chk("rst_dclr_drop", bus.det_clr, 1'b0);

      // Single byte 0xB6: eight bits then flush, done at T+10.
      clear_ctx();
      pat = 8'hB6;
      send_byte(pat);
      for (int i = 0; i < 8; i++) begin
`ifdef BSD_CTRL_LSB_FIRST_EN
         chk("b6_bit", bus.det_bit, pat[i]);
`else
         chk("b6_bit", bus.det_bit, pat[7-i]);
`endif
         chk("b6_en", bus.det_en, 1'b1);
         tick();
      end
      chk("b6_flush_en", bus.det_en, 1'b0);
      tick();
      chk("b6_done", bus.done, 1'b1);
`ifdef BSD_CTRL_LSB_FIRST_EN
      chk("b6_cnt", bus.match_cnt, 1);
`else
      chk("b6_cnt", bus.match_cnt, 2);
`endif
      tick();
      chk("b6_done_pulse", bus.done, 1'b0);

      // Back-to-back 0x0B, 0xB0.
      clear_ctx();
      obs_en_cnt = 0;
      obs_done_cnt = 0;
      send_byte(8'h0B);
      send_byte(8'hB0);
      idle(14);
      chk("b2b_en_cycles", obs_en_cnt, 16);
      chk("b2b_done_cnt", obs_done_cnt, 1);
`ifdef BSD_CTRL_LSB_FIRST_EN
      chk("b2b_cnt", bus.match_cnt, 0);
`else
      chk("b2b_cnt", bus.match_cnt, 2);
`endif

      // clr on the fourth bit of 0xFF.
      clear_ctx();
      send_byte(8'hFF);
      idle(3);
      bus.clr = 1'b1;
      tick();
      bus.clr = 1'b0;
      chk("clr_dclr", bus.det_clr, 1'b1);
      chk("clr_en", bus.det_en, 1'b0);
      chk("clr_busy", bus.busy, 1'b0);
      chk("clr_cnt", bus.match_cnt, 0);
      obs_done_cnt = 0;
      idle(12);
      chk("clr_no_done", obs_done_cnt, 0);

      // clr beats a simultaneous transfer.
      bus.clr = 1'b1;
      bus.byte_valid = 1'b1;
      bus.byte_in = 8'hAA;
      tick();
      bus.clr = 1'b0;
      bus.byte_valid = 1'b0;
      chk("clr_drop_busy", bus.busy, 1'b0);
      idle(3);

      // Saturation: a continuous "101" stream hits every third bit.
`ifdef BSD_CTRL_LSB_FIRST_EN
      sat_tab[0] = 8'h6D; sat_tab[1] = 8'hDB; sat_tab[2] = 8'hB6;
`else
      sat_tab[0] = 8'hB6; sat_tab[1] = 8'hDB; sat_tab[2] = 8'h6D;
`endif
      clear_ctx();
      for (int k = 0; k < 120; k++) send_byte(sat_tab[k % 3]);
      wait_done();
      chk("sat_cnt", bus.match_cnt, CNT_MAX);
      chk("sat_ovf", bus.ovf, 1'b1);
      idle(4);
      chk("sat_ovf_sticky", bus.ovf, 1'b1);
      bus.clr = 1'b1;
      tick();
      bus.clr = 1'b0;
      chk("sat_ovf_clr", bus.ovf, 1'b0);
      idle(2);

      // Bit order: 0x0D matches only when sent LSB first.
      clear_ctx();
      send_byte(8'h0D);
      wait_done();
`ifdef BSD_CTRL_LSB_FIRST_EN
      chk("order_0d", bus.match_cnt, 1);
`else
      chk("order_0d", bus.match_cnt, 0);
`endif
      idle(2);

      // Random traffic with occasional clr and rst.
      for (int c = 0; c < 600; c++) begin
         bus.byte_valid = ($urandom_range(0, 3) != 0);
         bus.byte_in    = 8'($urandom());
         bus.clr        = ($urandom_range(0, 59) == 0);
         rst            = ($urandom_range(0, 199) == 0);
         tick();
      end
      bus.byte_valid = 1'b0;
      bus.clr = 1'b0;
      rst = 1'b0;
      idle(15);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/bsd_stream_ctrl.md
BSD_STREAM_CTRL -- requirements
Module: bsd_stream_ctrl

Interface
- REQ-001: Parameter CNT_W, default 8, width of the match counter.
- REQ-002: Port clk, input, 1: sole clock; all state updates on the rising edge.
- REQ-003: Port rst, input, 1: reset, synchronous, active-high.
- REQ-004: Port clr, input, 1: synchronous soft clear; aborts the stream and zeroes the counters.
- REQ-005: Port byte_in, input, 8: byte to serialise into the detector.
- REQ-006: Port byte_valid, input, 1: byte_in is valid.
- REQ-007: Port byte_ready, output, 1: controller accepts a byte this cycle.
- REQ-008: Port det_bit, output, 1: serial bit to the sequence detector.
- REQ-009: Port det_en, output, 1: det_bit is valid this cycle.
- REQ-010: Port det_clr, output, 1: clears the detector state.
- REQ-011: Port det_hit, input, 1: detector match; registered, arrives 1 cycle after the matching bit.
- REQ-012: Port busy, output, 1: stream in progress (SHIFT or FLUSH).
- REQ-013: Port done, output, 1: one-cycle pulse; stream finished, count final.
- REQ-014: Port match_cnt, output, CNT_W: saturating count of det_hit cycles.
- REQ-015: Port ovf, output, 1: sticky flag; a hit arrived while match_cnt was at maximum.

Function
- REQ-016: The FSM SHALL have three states: IDLE, SHIFT and FLUSH.
- REQ-017: byte_ready SHALL be 1 in IDLE and in the last-bit cycle of SHIFT, and 0 otherwise.
- REQ-018: A transfer SHALL occur at a rising edge where byte_valid=1 and byte_ready=1; the accepted byte loads into the shift register.
- REQ-019: If a byte is accepted at edge T, det_en SHALL be 1 and det_bit SHALL carry bits 7..0 (MSB first) in cycles T+1..T+8.
- REQ-020: If a byte is accepted in the last-bit cycle, the next byte's first bit SHALL follow with no gap.
- REQ-021: If no byte is accepted in the last-bit cycle, the FSM SHALL enter FLUSH for 1 cycle with det_en=0, then IDLE; done SHALL be 1 in the first IDLE cycle.
- REQ-022: match_cnt SHALL increment at every edge where det_hit=1, in any state, and SHALL saturate at 2^CNT_W-1.
- REQ-023: A hit arriving while match_cnt is at maximum SHALL set ovf; ovf SHALL clear only on rst or clr.
- REQ-024: match_cnt SHALL be final when done=1.
- REQ-025: clr=1 at an edge SHALL force, in the following cycle: IDLE, det_en=0, busy=0, match_cnt=0, ovf=0, det_clr=1 for 1 cycle, and no done pulse.
- REQ-026: clr SHALL take priority over a byte transfer in the same cycle; the byte is dropped and byte_ready is ignored.
- REQ-027: det_clr SHALL be a registered output.
- REQ-028: det_bit SHALL be 0 whenever det_en=0.

Reset
- REQ-029: rst SHALL have priority over clr and over transfers.
- REQ-030: After any edge with rst=1, outputs SHALL be: state IDLE, byte_ready=1, det_bit=0, det_en=0, det_clr=1, busy=0, done=0, match_cnt=0, ovf=0.
- REQ-031: In the first cycle after rst deasserts, det_clr SHALL be 1, then 0.

Configuration
- REQ-032: Macro BSD_CTRL_LSB_FIRST_EN: when defined, bytes SHALL be serialised LSB first (bits 0..7); when undefined, MSB first (bits 7..0). Timing is unchanged either way.

Structure
- REQ-033: Package bsd_pkg SHALL hold the FSM state enum (IDLE, SHIFT, FLUSH) and the CNT_W default constant.
- REQ-034: Sub-module bsd_sat_cnt SHALL implement the saturating counter plus sticky ovf, with inc/clr inputs.

Verification
The bench uses a behavioural overlapping "1011" detector with a 1-cycle registered hit.
- REQ-035: Reset: rst=1 for 2 cycles -> byte_ready=1, det_clr=1, match_cnt=0, busy=0, done=0.
- REQ-036: Single byte 0xB6 -> det_bit 1,0,1,1,0,1,1,0 in cycles T+1..T+8; done at T+10; match_cnt=2.
- REQ-037: Back-to-back bytes 0x0B then 0xB0 -> 16 consecutive det_en cycles; one done pulse; match_cnt=2.
- REQ-038: clr on the 4th bit of 0xFF -> next cycle det_clr=1, det_en=0, busy=0, match_cnt=0; no done pulse.
- REQ-039: 128 back-to-back bytes of 0xBB -> 256 hits; match_cnt=255, ovf=1.
- REQ-040: With BSD_CTRL_LSB_FIRST_EN, byte 0x0D -> match_cnt=1; without it -> match_cnt=0.
